recognize_arbiter: RTL and testbench

//   Time-shares one "110" sequence recognizer (states S0..S3, overlapping) between NCH serial
//   bit-stream requesters. A round-robin arbiter grants one channel per cycle. The granted bit

---
 rtl/recognize_arbiter_if.sv | 24 ++
 rtl/recognize_arbiter.sv | 105 ++++++++++
 tb/tb_recognize_arbiter.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/recognize_arbiter_if.sv
// Request/grant/status bundle between serial requesters and the shared
// "110" recognizer.
interface recognize_arbiter_if #(
    parameter int NCH = 4,
    parameter int IDW = $clog2(NCH)
);
    logic [NCH-1:0]   req;
    logic [NCH-1:0]   din;
    logic [NCH-1:0]   clr;
    logic [NCH-1:0]   gnt;
    logic             hit;
    logic [IDW-1:0]   hit_ch;
    logic [2*NCH-1:0] st_ch;

    modport master (
        output req, din, clr,
        input  gnt, hit, hit_ch, st_ch
    );

    modport slave (
        input  req, din, clr,
        output gnt, hit, hit_ch, st_ch
    );
endinterface

// File: rtl/recognize_arbiter.sv
// One overlapping "110" recognizer time-shared between NCH serial channels
// by a round-robin arbiter; each channel keeps its own recognizer state.
module recognize_arbiter #(
    parameter int NCH = 4,
    parameter int IDW = $clog2(NCH)
) (
    input logic clk,
    input logic reset,
    recognize_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10,
        S3 = 2'b11
    } st_e;

    st_e            st_q [NCH];
    st_e            st_n [NCH];
    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] ptr_n;
    logic [IDW-1:0] gidx;
    logic [IDW-1:0] cand;
    logic [IDW-1:0] hit_ch_q;
    logic [IDW-1:0] hit_ch_n;
    logic           hit_q;
    logic           hit_n;
    logic           any;
    logic [NCH-1:0] elig;
    logic [NCH-1:0] gnt_c;

    function automatic st_e step(st_e s, logic b);
        step = S0;
        unique case (s)
            S0: step = b ? S1 : S0;
            S1: step = b ? S2 : S0;
            S2: step = b ? S2 : S3;
            S3: step = b ? S1 : S0;
        endcase
    endfunction

    // A clear wins over a request, so a cleared channel is never eligible.
    assign elig = bus.req & ~bus.clr;

    always_comb begin
        gnt_c = '0;
        gidx  = '0;
        cand  = '0;
        any   = 1'b0;
        for (int k = 1; k <= NCH; k++) begin
            cand = IDW'((int'(ptr_q) + k) % NCH);
            if (!any && elig[cand]) begin
                any  = 1'b1;
                gidx = cand;
            end
        end
        if (!reset) begin
            any = 1'b0;
        end
        if (any) begin
            gnt_c[gidx] = 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            st_n[i] = st_q[i];
            if (bus.clr[i]) begin
                st_n[i] = S0;
            end else if (gnt_c[i]) begin
                st_n[i] = step(st_q[i], bus.din[i]);
            end
        end
        ptr_n    = any ? gidx : ptr_q;
        hit_n    = any && (st_n[gidx] == S3);
        hit_ch_n = any ? gidx : hit_ch_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NCH; i++) begin
                st_q[i] <= S0;
            end
            ptr_q    <= IDW'(NCH - 1);
            hit_q    <= 1'b0;
            hit_ch_q <= '0;
        end else begin
            st_q     <= st_n;
            ptr_q    <= ptr_n;
            hit_q    <= hit_n;
            hit_ch_q <= hit_ch_n;
        end
    end

    always_comb begin
        bus.st_ch = '0;
        for (int i = 0; i < NCH; i++) begin
            bus.st_ch[2*i +: 2] = st_q[i];
        end
    end

    assign bus.gnt    = gnt_c;
    assign bus.hit    = hit_q;
    assign bus.hit_ch = hit_ch_q;
endmodule

// File: tb/tb_recognize_arbiter.sv
// Bench for recognize_arbiter: history-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_recognize_arbiter;
    localparam int NCH = 4;

    logic clk = 1'b0;
    logic reset;

    recognize_arbiter_if #(.NCH(NCH)) bus ();

    recognize_arbiter #(.NCH(NCH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;

    // Model: last three consumed bits and how many are valid since clear.
    logic [2:0] mh [NCH];
    int         ml [NCH];
    int         mptr;
    logic       mhit;
    logic [1:0] mhitch;
    int         mgi;
    logic [3:0] egnt;

    function automatic int st_of(logic [2:0] h, int len);
        if (len >= 3 && h == 3'b110) return 3;
        if (len >= 2 && h[1:0] == 2'b11) return 2;
        if (len >= 1 && h[0]) return 1;
        return 0;
    endfunction

    function automatic int mg_of(logic rs, logic [3:0] r,
                                 logic [3:0] c, int p);
        if (rs !== 1'b1) return -1;
        for (int k = 1; k <= NCH; k++)
            for (int i = 0; i < NCH; i++)
                if (i == (p + k) % NCH && r[i] && !c[i]) return i;
        return -1;
    endfunction

    assign mgi = mg_of(reset, bus.req, bus.clr, mptr);

    always_comb begin
        egnt = '0;
        for (int i = 0; i < NCH; i++)
            if (mgi == i) egnt[i] = 1'b1;
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NCH; i++) begin
                mh[i] <= '0;
                ml[i] <= 0;
            end
            mptr   <= NCH - 1;
            mhit   <= 1'b0;
            mhitch <= '0;
        end else begin
            mhit <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                if (bus.clr[i]) begin
                    mh[i] <= '0;
                    ml[i] <= 0;
                end else if (mgi == i) begin
                    mh[i] <= {mh[i][1:0], bus.din[i]};
                    ml[i] <= (ml[i] < 3) ? ml[i] + 1 : 3;
                    mhit  <= (st_of({mh[i][1:0], bus.din[i]},
                                    ml[i] + 1) == 3);
                end
            end
            if (mgi >= 0) begin
                mptr   <= mgi;
                mhitch <= 2'(mgi);
            end
        end
    end

    function automatic logic [7:0] exp_st();
        logic [7:0] e;
        e = '0;
        for (int i = 0; i < NCH; i++)
            e[2*i +: 2] = 2'(st_of(mh[i], ml[i]));
        return e;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("m_gnt", 32'(bus.gnt), 32'(egnt));
        chk("m_hit", 32'(bus.hit), 32'(mhit));
        chk("m_hit_ch", 32'(bus.hit_ch), 32'(mhitch));
        chk("m_st_ch", 32'(bus.st_ch), 32'(exp_st()));
    end

    task automatic cyc(logic [3:0] r, logic [3:0] d, logic [3:0] c);
        @(posedge clk);
        #2;
        bus.req = r;
        bus.din = d;
        bus.clr = c;
        @(negedge clk);
    endtask

    int cnt [NCH];
    int p0;
    int p3;
    int hq [$];
    int h0;
    int h1;

    initial begin
        reset   = 1'b0;
        bus.req = 4'hF;
        bus.din = '0;
        bus.clr = '0;

        // Reset holds everything off even with all requests high.
        repeat (2) @(negedge clk);
        #1;
        chk("rst_gnt", 32'(bus.gnt), 32'h0);
        chk("rst_hit", 32'(bus.hit), 32'h0);
        chk("rst_st", 32'(bus.st_ch), 32'h0);
        @(posedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        chk("first_gnt", 32'(bus.gnt), 32'h1);

        // Single stream on ch2: 1,1,0.
        cyc(4'b0100, 4'b0100, 4'b0000);
        chk("s_gnt", 32'(bus.gnt), 32'h4);
        cyc(4'b0100, 4'b0100, 4'b0000);
        chk("s_st1", 32'(bus.st_ch[5:4]), 32'd1);
        chk("s_hit1", 32'(bus.hit), 32'd0);
        cyc(4'b0100, 4'b0000, 4'b0000);
        chk("s_st2", 32'(bus.st_ch[5:4]), 32'd2);
        chk("s_hit2", 32'(bus.hit), 32'd0);
        cyc(4'b0000, 4'b0000, 4'b0000);
        chk("s_st3", 32'(bus.st_ch[5:4]), 32'd3);
        chk("s_hit3", 32'(bus.hit), 32'd1);
        chk("s_hitch", 32'(bus.hit_ch), 32'd2);
        cyc(4'b0000, 4'b0000, 4'b0000);
        chk("s_hit_drop", 32'(bus.hit), 32'd0);
        chk("s_hitch_hold", 32'(bus.hit_ch), 32'd2);

        // Round robin from ptr=2: 1000,0001,0010,0100,...
        for (int i = 0; i < NCH; i++) cnt[i] = 0;
        for (int n = 0; n < 8; n++) begin
            cyc(4'hF, 4'hF, 4'h0);
            if (n == 0) chk("rr_first", 32'(bus.gnt), 32'h8);
            for (int i = 0; i < NCH; i++) cnt[i] += int'(bus.gnt[i]);
        end
        for (int i = 0; i < NCH; i++)
            chk("rr_count", 32'(cnt[i]), 32'd2);

        // Clear all, then park the pointer on ch3.
        cyc(4'h0, 4'h0, 4'hF);
        cyc(4'b1000, 4'b0000, 4'b0111);
        chk("park_gnt", 32'(bus.gnt), 32'h8);

        // Interleave ch0 and ch3, each sending 1,1,0.
        p0 = 0;
        p3 = 0;
        hq.delete();
        for (int n = 0; n < 12 && (p0 < 3 || p3 < 3); n++) begin
            cyc({p3 < 3, 2'b00, p0 < 3},
                {p3 < 2, 2'b00, p0 < 2}, 4'h0);
            if (bus.hit) hq.push_back(int'(bus.hit_ch));
            if (bus.gnt[0]) p0++;
            if (bus.gnt[3]) p3++;
        end
        cyc(4'h0, 4'h0, 4'h0);
        if (bus.hit) hq.push_back(int'(bus.hit_ch));
        chk("il_done", 32'(p0 + p3), 32'd6);
        chk("il_nhits", 32'(hq.size()), 32'd2);
        h0 = (hq.size() > 0) ? hq[0] : -1;
        h1 = (hq.size() > 1) ? hq[1] : -1;
        chk("il_hit0", 32'(h0), 32'd0);
        chk("il_hit1", 32'(h1), 32'd3);
        chk("il_st0", 32'(bus.st_ch[1:0]), 32'd3);
        chk("il_st3", 32'(bus.st_ch[7:6]), 32'd3);

        // Clear ch1 while it sits in S2 and requests.
        cyc(4'b0010, 4'b0010, 4'h0);
        cyc(4'b0010, 4'b0010, 4'h0);
        chk("c_st1", 32'(bus.st_ch[3:2]), 32'd1);
        cyc(4'b0010, 4'b0000, 4'b0010);
        chk("c_gnt", 32'(bus.gnt), 32'h0);
        chk("c_st2", 32'(bus.st_ch[3:2]), 32'd2);
        cyc(4'b0010, 4'b0000, 4'b0000);
        chk("c_st0", 32'(bus.st_ch[3:2]), 32'd0);
        chk("c_hit", 32'(bus.hit), 32'd0);
        chk("c_gnt1", 32'(bus.gnt), 32'h2);
        cyc(4'h0, 4'h0, 4'h0);
        chk("c_st_after", 32'(bus.st_ch[3:2]), 32'd0);
        chk("c_hit_after", 32'(bus.hit), 32'd0);

        // Async reset between edges with ch2 in S2.
        cyc(4'b0100, 4'b0100, 4'h0);
        cyc(4'b0100, 4'b0100, 4'h0);
        cyc(4'h0, 4'h0, 4'h0);
        chk("a_st2", 32'(bus.st_ch[5:4]), 32'd2);
        #1 reset = 1'b0;
        #1;
        chk("a_st_clr", 32'(bus.st_ch), 32'h0);
        chk("a_hit", 32'(bus.hit), 32'd0);
        chk("a_gnt", 32'(bus.gnt), 32'h0);
        #1 reset = 1'b1;
        cyc(4'hF, 4'h0, 4'h0);
        chk("a_ptr", 32'(bus.gnt), 32'h1);
        cyc(4'b0100, 4'b0000, 4'h0);
        chk("a_gnt2", 32'(bus.gnt), 32'h4);
        cyc(4'h0, 4'h0, 4'h0);
        chk("a_nohit", 32'(bus.hit), 32'd0);
        chk("a_st_ch2", 32'(bus.st_ch[5:4]), 32'd0);
        cyc(4'h0, 4'h0, 4'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
